// File: rtl/key_mode_pkg.sv
// -----------------------------------------------------------------------------
// key_mode_pkg
// Shared constants for the key-driven display-mode controller:
//   - FSM state encoding (IDLE / WAIT2)
//   - default double-click window for a 50 MHz clock (300 ms)
//   - commit-type codes produced by the FSM and consumed by the mode update
// Optional feature macro used by the files of this slice: KEY_MODE_LED_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package key_mode_pkg;

  // FSM state encoding; kept as plain localparams for legacy-tool friendliness
  localparam logic [0:0] ST_IDLE  = 1'b0;  // no press pending
  localparam logic [0:0] ST_WAIT2 = 1'b1;  // first press seen, waiting for a second

  // 300 ms at 50 MHz
  localparam int DBL_WIN_50M = 15_000_000;

  // What the FSM decided to do with the mode register this cycle
  typedef logic [1:0] cmt_t;
  localparam cmt_t CMT_NONE = 2'd0;  // no commit
  localparam cmt_t CMT_NEXT = 2'd1;  // single click: mode + 1 with wrap
  localparam cmt_t CMT_PREV = 2'd2;  // double click: mode - 1 with wrap
  localparam cmt_t CMT_ZERO = 2'd3;  // key B: back to mode 0

endpackage

// File: rtl/key_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_mode_ctrl_if
// Bundles the key inputs and mode outputs of key_mode_ctrl.
//   key_a_n  : debounced key A, active-low press pulse   (master -> slave)
//   key_b_n  : debounced key B, active-low press pulse   (master -> slave)
//   mode     : current display mode                      (slave -> master)
//   mode_chg : one-cycle pulse after every mode commit   (slave -> master)
//   led      : one-hot mode indicator, only with KEY_MODE_LED_EN
// Modports: master = key filter side / bench, slave = key_mode_ctrl.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface key_mode_ctrl_if #(
  parameter int MODE_W   = 2
`ifdef KEY_MODE_LED_EN
  , parameter int MODE_NUM = 4
`endif
);

  logic              key_a_n;
  logic              key_b_n;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;

`ifdef KEY_MODE_LED_EN
  logic [MODE_NUM-1:0] led;

  modport master (output key_a_n, key_b_n, input mode, mode_chg, led);
  modport slave  (input key_a_n, key_b_n, output mode, mode_chg, led);
`else
  modport master (output key_a_n, key_b_n, input mode, mode_chg);
  modport slave  (input key_a_n, key_b_n, output mode, mode_chg);
`endif

endinterface

// File: rtl/key_edge_det.sv
// -----------------------------------------------------------------------------
// key_edge_det
// Turns an active-low key level into a one-cycle press event: ev is high while
// key_n is low and was high on the previous cycle. A key held low yields a
// single event; release produces nothing.
// Ports:
//   clk   : system clock
//   rst   : synchronous reset, active-high (delay flop resets to "released")
//   key_n : debounced key, active-low
//   ev    : press event, combinational from key_n and the delayed copy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic ev
);

  logic r_key_q;

  // Reset to 1 so a key already low when reset releases still counts as a press.
  always_ff @(posedge clk) begin
    if (rst) r_key_q <= 1'b1;
    else     r_key_q <= key_n;
  end

  assign ev = ~key_n & r_key_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// key_mode_ctrl
// Converts key press pulses into a display-mode index for the VGA selector.
//   key A single click -> next mode (wraps MODE_NUM-1 -> 0)
//   key A double click -> previous mode (wraps 0 -> MODE_NUM-1)
//   key B              -> mode 0, cancels any pending click
// A double click is a second key A press sampled within DBL_WIN cycles of the
// first; a press on the same edge as the window timeout counts as double.
// Ports:
//   clk : system clock (50 MHz nominal)
//   rst : synchronous reset, active-high, overrides every event
//   bus : key_mode_ctrl_if.slave (key_a_n, key_b_n in; mode, mode_chg, led out)
// Optional feature: KEY_MODE_LED_EN adds the registered one-hot led output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter int MODE_NUM = 4,
  parameter int MODE_W   = 2,
  parameter int DBL_WIN  = DBL_WIN_50M,
  parameter int CNT_W    = 24
) (
  input  logic           clk,
  input  logic           rst,
  key_mode_ctrl_if.slave bus
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DBL_WIN - 1);

  logic              w_ev_a;
  logic              w_ev_b;
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_win_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  cmt_t              w_cmt;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] w_mode_nxt;
  logic              r_mode_chg;

  key_edge_det u_edge_a (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_a_n),
    .ev    (w_ev_a)
  );

  key_edge_det u_edge_b (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_b_n),
    .ev    (w_ev_b)
  );

  // Next-state / commit decision. Key B is checked first so it also swallows
  // a key A event arriving in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    w_cmt       = CMT_NONE;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_win_cnt;
    if (w_ev_b) begin
      w_cmt       = CMT_ZERO;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev_a) begin
            w_state_nxt = ST_WAIT2;
            w_cnt_nxt   = '0;
          end
        end
        ST_WAIT2: begin
          if (w_ev_a) begin
            w_cmt       = CMT_PREV;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_win_cnt == CNT_LAST) begin
            w_cmt       = CMT_NEXT;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_win_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    case (w_cmt)
      CMT_NEXT: w_mode_nxt = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
      CMT_PREV: w_mode_nxt = (r_mode == '0) ? MODE_LAST : r_mode - 1'b1;
      CMT_ZERO: w_mode_nxt = '0;
      default:  w_mode_nxt = r_mode;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_win_cnt  <= '0;
      r_mode     <= '0;
      r_mode_chg <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_win_cnt  <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
      // Pulses on every commit, including key B while already in mode 0.
      r_mode_chg <= (w_cmt != CMT_NONE);
    end
  end

  assign bus.mode     = r_mode;
  assign bus.mode_chg = r_mode_chg;

`ifdef KEY_MODE_LED_EN
  logic [MODE_NUM-1:0] r_led;

  // Registered from the next mode so led and mode always change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_led <= MODE_NUM'(1);
    else     r_led <= MODE_NUM'(1) << w_mode_nxt;
  end

  assign bus.led = r_led;
`endif

endmodule

// File: tb/tb_key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_mode_ctrl
// Self-checking bench for key_mode_ctrl with MODE_NUM=4, MODE_W=2, DBL_WIN=5.
// Each cycle's inputs come with the outputs expected right after the next edge;
// the expectation is queued when the inputs are driven and compared after the edge.
// led is checked too when KEY_MODE_LED_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_mode_ctrl;

  localparam int MODE_NUM = 4;
  localparam int MODE_W   = 2;
  localparam int DBL_WIN  = 5;
  localparam int CNT_W    = 4;

  typedef struct {
    logic              ka;
    logic              kb;
    logic              rs;
    logic [MODE_W-1:0] mode;
    logic              chg;
    string             name;
  } vec_t;

  typedef struct {
    logic [MODE_W-1:0] mode;
    logic              chg;
    string             name;
  } exp_t;

  logic clk;
  logic rst;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef KEY_MODE_LED_EN
  key_mode_ctrl_if #(.MODE_W(MODE_W), .MODE_NUM(MODE_NUM)) bus ();
`else
  key_mode_ctrl_if #(.MODE_W(MODE_W)) bus ();
`endif

  key_mode_ctrl #(
    .MODE_NUM (MODE_NUM),
    .MODE_W   (MODE_W),
    .DBL_WIN  (DBL_WIN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void add(input logic ka, input logic kb, input logic rs,
                              input logic [MODE_W-1:0] m, input logic c, input string nm);
    vec_t v;
    v.ka = ka; v.kb = kb; v.rs = rs; v.mode = m; v.chg = c; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n, input logic [MODE_W-1:0] m, input string nm);
    for (int i = 0; i < n; i++) add(1'b1, 1'b1, 1'b0, m, 1'b0, nm);
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic ka, input logic kb, input logic rs,
                      input logic [MODE_W-1:0] m, input logic c, input string nm);
    exp_t e;
    exp_t got;
    bus.key_a_n = ka;
    bus.key_b_n = kb;
    rst         = rs;
    e.mode = m; e.chg = c; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.name, ".mode"},     32'(bus.mode),     32'(got.mode));
    check({got.name, ".mode_chg"}, 32'(bus.mode_chg), 32'(got.chg));
`ifdef KEY_MODE_LED_EN
    check({got.name, ".led"}, 32'(bus.led), 32'(MODE_NUM'(1) << got.mode));
`endif
  endtask

  initial begin
    bus.key_a_n = 1'b1;
    bus.key_b_n = 1'b1;
    rst         = 1'b1;

    // Reset, then quiet
    add(1, 1, 1, 0, 0, "rst0");
    add(1, 1, 1, 0, 0, "rst1");
    idle(20, 0, "rst_idle");

    // Single click: press at t0, commit 0->1 at t0+5
    add(0, 1, 0, 0, 0, "single_press");
    idle(4, 0, "single_wait");
    add(1, 1, 0, 1, 1, "single_commit");
    idle(3, 1, "single_after");

    // Key B back to 0, then double click at t0/t0+3 wraps 0->3
    add(1, 0, 0, 0, 1, "b_clear");
    idle(1, 0, "b_clear_after");
    add(0, 1, 0, 0, 0, "dbl_p1");
    idle(2, 0, "dbl_gap");
    add(0, 1, 0, 3, 1, "dbl_wrap");
    idle(6, 3, "dbl_after");

    // Second press exactly at t0+5 (timeout edge) is a double: 3->2
    add(0, 1, 0, 3, 0, "edge5_p1");
    idle(4, 3, "edge5_gap");
    add(0, 1, 0, 2, 1, "edge5_dbl");
    idle(3, 2, "edge5_after");

    // Key B two cycles after A cancels the pending single
    add(0, 1, 0, 2, 0, "bcan_p1");
    idle(1, 2, "bcan_gap");
    add(1, 0, 0, 0, 1, "bcan_b");
    idle(8, 0, "bcan_no_commit");

    // Two singles back to mode 2 (second press right after the first commit)
    add(0, 1, 0, 0, 0, "up_p1");
    idle(4, 0, "up_w1");
    add(1, 1, 0, 1, 1, "up_c1");
    add(0, 1, 0, 1, 0, "up_p2");
    idle(4, 1, "up_w2");
    add(1, 1, 0, 2, 1, "up_c2");
    idle(1, 2, "up_after");

    // A and B in the same cycle: B wins, A dropped, no later commit
    add(0, 0, 0, 0, 1, "ab_same");
    idle(8, 0, "ab_idle");

    // Press at t0+6 comes after the single commit and opens a fresh window
    add(0, 1, 0, 0, 0, "edge6_p1");
    idle(4, 0, "edge6_gap");
    add(1, 1, 0, 1, 1, "edge6_single");
    add(0, 1, 0, 1, 0, "edge6_p2");
    idle(4, 1, "edge6_w2");
    add(1, 1, 0, 2, 1, "edge6_single2");
    idle(2, 2, "edge6_after");

    foreach (vecs[i])
      step(vecs[i].ka, vecs[i].kb, vecs[i].rs, vecs[i].mode, vecs[i].chg, vecs[i].name);

    // Key A held low for 20 cycles: one single commit 2->3 only
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, (i >= 5) ? 2'd3 : 2'd2, (i == 5), "held");
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 3, 0, "held_release");

    // Reset while in WAIT2: mode cleared, the pending single never fires
    step(0, 1, 0, 3, 0, "rw_p1");
    step(1, 1, 0, 3, 0, "rw_wait");
    step(1, 1, 1, 0, 0, "rw_rst");
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 0, 0, "rw_after");

    // Key B in mode 0 still pulses mode_chg
    step(1, 0, 0, 0, 1, "b_same_val");
    step(1, 1, 0, 0, 0, "b_same_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
